// File: rtl/lfsr_rand_stream.sv
// Fibonacci-LFSR random word source with valid/ready output and zero-safe run-time reseeding.
// Optional transfer counter (output word_cnt) is enabled by defining RAND_STREAM_STATS_EN.
module lfsr_rand_stream #(
    parameter int                LFSR_W = 20,
    parameter int                OUT_W  = 12,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'h0001_2345)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              rand_ready,
    output logic              rand_valid,
    output logic [OUT_W-1:0]  rand_num,
    output logic              lockup
`ifdef RAND_STREAM_STATS_EN
    ,
    output logic [15:0]       word_cnt
`endif
);

    // Feedback tap masks, bit k set for 1-indexed tap k+1.
    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            8:       tap_mask = 32'h0000_00B8;
            12:      tap_mask = 32'h0000_0829;
            16:      tap_mask = 32'h0000_D008;
            20:      tap_mask = 32'h0009_0000;
            24:      tap_mask = 32'h00E1_0000;
            32:      tap_mask = 32'h8020_0003;
            default: tap_mask = 32'h0000_0000;
        endcase
    endfunction

    if (!(LFSR_W == 8 || LFSR_W == 12 || LFSR_W == 16 ||
          LFSR_W == 20 || LFSR_W == 24 || LFSR_W == 32)) begin : g_bad_lfsr_w
        $error("lfsr_rand_stream: unsupported LFSR_W %0d", LFSR_W);
    end
    if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
        $error("lfsr_rand_stream: OUT_W %0d out of range 1..LFSR_W", OUT_W);
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_rand_stream: SEED must be nonzero");
    end

    localparam logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(tap_mask(LFSR_W));
    localparam int                CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [LFSR_W-1:0]  lfsr_r;
    logic [OUT_W-1:0]   shreg_r;
    logic [OUT_W-1:0]   shreg_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [OUT_W-1:0]   rand_num_r;
    logic               rand_valid_r;
    logic               lockup_r;
    logic               out_bit_s;
    logic               fb_s;
    logic               last_bit_s;
    logic               xfer_s;
    logic               block_s;
    logic               step_s;

    assign out_bit_s   = lfsr_r[LFSR_W-1];
    assign fb_s        = ^(lfsr_r & TAP_MASK);
    assign shreg_nxt_s = OUT_W'({shreg_r, out_bit_s});
    assign last_bit_s  = (cnt_r == CNT_LAST);
    assign xfer_s      = rand_valid_r && rand_ready;
    // A completing step must not overwrite a word the consumer has not taken.
    assign block_s     = last_bit_s && rand_valid_r && !rand_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (seed_load) begin
            state_nxt_s = COLLECT;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (enable && block_s) begin
                        state_nxt_s = STALL;
                    end else begin
                        state_nxt_s = COLLECT;
                    end
                end
                STALL: begin
                    if (xfer_s) begin
                        state_nxt_s = COLLECT;
                    end else begin
                        state_nxt_s = STALL;
                    end
                end
                default: state_nxt_s = COLLECT;
            endcase
        end
    end

    // Step strobe decoded from state
    always_comb begin
        step_s = 1'b0;
        case (state_r)
            COLLECT: begin
                if (!seed_load && enable && !block_s) begin
                    step_s = 1'b1;
                end else begin
                    step_s = 1'b0;
                end
            end
            STALL:   step_s = 1'b0;
            default: step_s = 1'b0;
        endcase
    end

    // LFSR, word assembly and output handshake registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r       <= SEED;
            shreg_r      <= '0;
            cnt_r        <= '0;
            rand_num_r   <= '0;
            rand_valid_r <= 1'b0;
            lockup_r     <= 1'b0;
        end else if (seed_load) begin
            lfsr_r       <= (seed_in == '0) ? SEED : seed_in;
            shreg_r      <= '0;
            cnt_r        <= '0;
            rand_valid_r <= 1'b0;
            lockup_r     <= (seed_in == '0);
        end else begin
            lockup_r <= 1'b0;
            if (step_s) begin
                lfsr_r  <= {lfsr_r[LFSR_W-2:0], fb_s};
                shreg_r <= shreg_nxt_s;
                if (last_bit_s) begin
                    cnt_r        <= '0;
                    rand_num_r   <= shreg_nxt_s;
                    rand_valid_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (xfer_s) begin
                        rand_valid_r <= 1'b0;
                    end else begin
                        rand_valid_r <= rand_valid_r;
                    end
                end
            end else if (xfer_s) begin
                rand_valid_r <= 1'b0;
            end else begin
                rand_valid_r <= rand_valid_r;
            end
        end
    end

`ifdef RAND_STREAM_STATS_EN
    logic [15:0] word_cnt_r;

    // Saturating count of accepted words, cleared on reseed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt_r <= 16'h0000;
        end else if (seed_load) begin
            word_cnt_r <= 16'h0000;
        end else if (xfer_s && (word_cnt_r != 16'hFFFF)) begin
            word_cnt_r <= word_cnt_r + 16'h0001;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;
`endif

    assign rand_valid = rand_valid_r;
    assign rand_num   = rand_num_r;
    assign lockup     = lockup_r;

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Self-checking bench for lfsr_rand_stream: directed handshake/reseed steps, random
// traffic against a bit-stream reference model, and OUT_W=1 free-run period checks.
module tb_lfsr_rand_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        en = 1'b0, sl = 1'b0, rdy = 1'b0;
    logic [19:0] sin = 20'd0;
    logic        a_valid, a_lock;
    logic [11:0] a_num;

    logic        fr_en = 1'b0, fr_sl = 1'b0, one = 1'b1;
    logic [7:0]  z8  = 8'd0;
    logic [11:0] z12 = 12'd0;
    logic [15:0] z16 = 16'd0;
    logic        b8_valid, b8_num, b8_lock;
    logic        b12_valid, b12_num, b12_lock;
    logic        b16_valid, b16_num, b16_lock;
`ifdef RAND_STREAM_STATS_EN
    logic [15:0] a_wcnt, b8_wcnt, b12_wcnt, b16_wcnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_wcnt  = 0;
    logic [31:0] ma_state = 32'h12345;
    logic        q8[$];
    logic        q12[$];
    logic        q16[$];

    lfsr_rand_stream #(.LFSR_W(20), .OUT_W(12)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en), .seed_load(sl), .seed_in(sin),
        .rand_ready(rdy), .rand_valid(a_valid), .rand_num(a_num), .lockup(a_lock)
`ifdef RAND_STREAM_STATS_EN
        , .word_cnt(a_wcnt)
`endif
    );

    lfsr_rand_stream #(.LFSR_W(8), .OUT_W(1)) dut_b8 (
        .clk(clk), .reset_n(reset_n), .enable(fr_en), .seed_load(fr_sl), .seed_in(z8),
        .rand_ready(one), .rand_valid(b8_valid), .rand_num(b8_num), .lockup(b8_lock)
`ifdef RAND_STREAM_STATS_EN
        , .word_cnt(b8_wcnt)
`endif
    );

    lfsr_rand_stream #(.LFSR_W(12), .OUT_W(1)) dut_b12 (
        .clk(clk), .reset_n(reset_n), .enable(fr_en), .seed_load(1'b0), .seed_in(z12),
        .rand_ready(one), .rand_valid(b12_valid), .rand_num(b12_num), .lockup(b12_lock)
`ifdef RAND_STREAM_STATS_EN
        , .word_cnt(b12_wcnt)
`endif
    );

    lfsr_rand_stream #(.LFSR_W(16), .OUT_W(1)) dut_b16 (
        .clk(clk), .reset_n(reset_n), .enable(fr_en), .seed_load(1'b0), .seed_in(z16),
        .rand_ready(one), .rand_valid(b16_valid), .rand_num(b16_num), .lockup(b16_lock)
`ifdef RAND_STREAM_STATS_EN
        , .word_cnt(b16_wcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR step built from the published tap lists.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w);
        int   taps[4];
        logic fb;
        case (w)
            8:       taps = '{8, 6, 5, 4};
            12:      taps = '{12, 6, 4, 1};
            16:      taps = '{16, 15, 13, 4};
            default: taps = '{20, 17, 0, 0};
        endcase
        fb = 1'b0;
        foreach (taps[i]) if (taps[i] != 0) fb ^= s[taps[i]-1];
        lfsr_step = ((s << 1) | {31'd0, fb}) & ((32'd1 << w) - 32'd1);
    endfunction

    // The next n output bits (MSB of state, step by step) packed MSB-first.
    function automatic logic [31:0] word_from(input logic [31:0] s0, input int w, input int n);
        logic [31:0] s = s0;
        logic [31:0] acc = 32'd0;
        for (int i = 0; i < n; i++) begin
            acc = (acc << 1) | {31'd0, s[w-1]};
            s   = lfsr_step(s, w);
        end
        word_from = acc;
    endfunction

    function automatic logic [31:0] advance(input logic [31:0] s0, input int w, input int n);
        logic [31:0] s = s0;
        for (int i = 0; i < n; i++) s = lfsr_step(s, w);
        advance = s;
    endfunction

    // One clock: scoreboard any transfer, apply reseed to the model, then check lockup and hold rules.
    task automatic tick();
        logic        pv, pr, psl, pzero;
        logic [11:0] pnum;
        logic [31:0] wd;
        pv = a_valid; pr = rdy; psl = sl; pzero = (sin == 20'd0); pnum = a_num;
        if (a_valid && rdy) begin
            wd       = word_from(ma_state, 20, 12);
            ma_state = advance(ma_state, 20, 12);
            chk("xfer_word", 32'(a_num), wd);
            if (m_wcnt < 65535) m_wcnt++;
        end
        if (sl) begin
            ma_state = (sin == 20'd0) ? 32'h12345 : 32'(sin);
            m_wcnt   = 0;
        end
        if (b8_valid)  q8.push_back(b8_num);
        if (b12_valid) q12.push_back(b12_num);
        if (b16_valid) q16.push_back(b16_num);
        @(posedge clk);
        #1;
        chk("lockup", 32'(a_lock), 32'(psl && pzero));
        if (pv && !pr && !psl) begin
            chk("hold_valid", 32'(a_valid), 32'd1);
            chk("hold_num", 32'(a_num), 32'(pnum));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; en = 1'b0; sl = 1'b0; rdy = 1'b0; sin = 20'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_num", 32'(a_num), 32'd0);
        chk("rst_lockup", 32'(a_lock), 32'd0);
        chk("rst_b8_valid", 32'(b8_valid), 32'd0);
`ifdef RAND_STREAM_STATS_EN
        chk("rst_word_cnt", 32'(a_wcnt), 32'd0);
`endif
        reset_n  = 1'b1;
        ma_state = 32'h12345;
        m_wcnt   = 0;
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] acc;
        int          f0;

        // First word after reset with free-flowing consumer.
        do_reset();
        en = 1'b1; rdy = 1'b1;
        repeat (11) tick();
        chk("t1_valid_early", 32'(a_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(a_valid), 32'd1);
        chk("t1_num", 32'(a_num), 32'h123);
        repeat (12) tick();
        chk("t1_valid2", 32'(a_valid), 32'd1);
        tick();

        // Back-pressure: word held, stall, then release.
        do_reset();
        en = 1'b1; rdy = 1'b0;
        repeat (12) tick();
        chk("t2_valid", 32'(a_valid), 32'd1);
        chk("t2_num", 32'(a_num), 32'h123);
        repeat (17) tick();
        chk("t2_stall_valid", 32'(a_valid), 32'd1);
        chk("t2_stall_num", 32'(a_num), 32'h123);
        rdy = 1'b1;
        tick();
        chk("t2_after_xfer", 32'(a_valid), 32'd0);
        tick();
        chk("t2_next_valid", 32'(a_valid), 32'd1);
        chk("t2_next_num", 32'(a_num), word_from(ma_state, 20, 12));

        // Zero reseed while a word is pending.
        rdy = 1'b0; sl = 1'b1; sin = 20'd0;
        tick();
        chk("t3_discard", 32'(a_valid), 32'd0);
        sl = 1'b0; rdy = 1'b1;
        repeat (11) tick();
        chk("t3_valid_early", 32'(a_valid), 32'd0);
        tick();
        chk("t3_valid", 32'(a_valid), 32'd1);
        chk("t3_num", 32'(a_num), 32'h123);

        // Reseed mid-word.
        repeat (5) tick();
        sl = 1'b1; sin = 20'hABCDE;
        tick();
        chk("t4_valid0", 32'(a_valid), 32'd0);
        sl = 1'b0;
        repeat (11) tick();
        chk("t4_valid_early", 32'(a_valid), 32'd0);
        tick();
        chk("t4_valid", 32'(a_valid), 32'd1);
        chk("t4_num", 32'(a_num), 32'hABC);
        tick();

        // Random traffic against the stream model.
        for (int c = 0; c < 3000; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            sl  = ($urandom_range(0, 99) == 0);
            sin = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom);
            tick();
        end
        sl = 1'b0; en = 1'b0; rdy = 1'b0;
`ifdef RAND_STREAM_STATS_EN
        chk("rand_word_cnt", 32'(a_wcnt), 32'(m_wcnt));
`endif

        // Free-run of the OUT_W=1 instances.
        do_reset();
        fr_en = 1'b1;
        repeat (4200) tick();
        chk("fr8_len", 32'(q8.size() >= 263), 32'd1);
        chk("fr12_len", 32'(q12.size() >= 4107), 32'd1);
        chk("fr16_len", 32'(q16.size() >= 2000), 32'd1);
        s = 32'h45; f0 = n_fail;
        for (int i = 0; i < 263; i++) begin
            chk("fr8_bit", 32'(q8[i]), {31'd0, s[7]});
            s = lfsr_step(s, 8);
            if (n_fail > f0) break;
        end
        acc = 32'd0;
        for (int i = 255; i < 263; i++) acc = (acc << 1) | 32'(q8[i]);
        chk("fr8_period", acc, 32'h45);
        s = 32'h345; f0 = n_fail;
        for (int i = 0; i < 4107; i++) begin
            chk("fr12_bit", 32'(q12[i]), {31'd0, s[11]});
            s = lfsr_step(s, 12);
            if (n_fail > f0) break;
        end
        acc = 32'd0;
        for (int i = 4095; i < 4107; i++) acc = (acc << 1) | 32'(q12[i]);
        chk("fr12_period", acc, 32'h345);
        s = 32'h2345; f0 = n_fail;
        for (int i = 0; i < 2000; i++) begin
            chk("fr16_bit", 32'(q16[i]), {31'd0, s[15]});
            s = lfsr_step(s, 16);
            if (n_fail > f0) break;
        end

`ifdef RAND_STREAM_STATS_EN
        repeat (62000) tick();
        chk("stats_saturate", 32'(b8_wcnt), 32'h0000FFFF);
        fr_sl = 1'b1;
        tick();
        fr_sl = 1'b0;
        chk("stats_clear", 32'(b8_wcnt), 32'd0);
`endif
        fr_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
